axis_period_packer: RTL and testbench

Downstream AXI-Stream consumer of the LFSR generator's `m_axis` output. It buffers the incoming words in a small synchronous FIFO and re-emits them on an AXI-Stream master with `tlast` framing every `PKT_LEN` beats. In parallel it measures the generator's sequence period by capturing a reference word and counting accepted beats until that word recurs. It sits between the AXI-Lite-controlled LFSR and the DMA/packet sink.

---
 rtl/axis_pkg.sv | 15 +
 rtl/axis_period_packer_if.sv | 17 +
 rtl/axis_sync_fifo.sv | 48 ++++
 rtl/axis_period_packer.sv | 128 ++++++++++++
 tb/tb_axis_period_packer.sv | 249 ++++++++++++++++++++++++
 5 files changed

// File: rtl/axis_pkg.sv
// Shared types and constants for the period packer slice.
//   PERIOD_W              : width of the period counter / result
//   C_AXIS_DATA_WIDTH_DEF : default stream data width
//   meas_state_e          : period measurement FSM states
//   sat_inc               : saturating increment of a period count
package axis_pkg;
  localparam int PERIOD_W              = 16;
  localparam int C_AXIS_DATA_WIDTH_DEF = 32;

  typedef enum logic {IDLE, MEASURE} meas_state_e;

  function automatic logic [PERIOD_W-1:0] sat_inc(input logic [PERIOD_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction
endpackage

// File: rtl/axis_period_packer_if.sv
// AXI-Stream bundle used on both sides of the packer.
//   tdata/tvalid/tlast : source -> sink
//   tready             : sink -> source
// master modport drives the payload, slave modport drives tready.
interface axis_period_packer_if
  import axis_pkg::*;
#(
  parameter int W = C_AXIS_DATA_WIDTH_DEF
) ();
  logic [W-1:0] tdata;
  logic         tvalid;
  logic         tready;
  logic         tlast;

  modport master (output tdata, output tvalid, output tlast, input  tready);
  modport slave  (input  tdata, input  tvalid, input  tlast, output tready);
endinterface

// File: rtl/axis_sync_fifo.sv
// Synchronous FIFO with first-word fall-through from registered storage.
//   clk/rst            : clock, synchronous active-high reset
//   wr_en/wr_data/full : write side (writes ignored while full)
//   rd_en/rd_data/empty: read side; rd_data shows the head, 0 while empty
//   level              : occupancy 0..DEPTH
module axis_sync_fifo #(
  parameter int W     = 32,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [W-1:0]             wr_data,
  output logic                     full,
  input  logic                     rd_en,
  output logic [W-1:0]             rd_data,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);
  localparam int AW = $clog2(DEPTH);

  // Extra MSB on each pointer separates full from empty.
  logic [AW:0]  wr_ptr, rd_ptr;
  logic [W-1:0] mem [DEPTH];
  logic         wr_fire, rd_fire;

  assign level   = wr_ptr - rd_ptr;
  assign full    = (level == (AW+1)'(DEPTH));
  assign empty   = (level == '0);
  assign wr_fire = wr_en && !full;
  assign rd_fire = rd_en && !empty;
  // Zeroed while empty so stale storage never leaks onto the bus.
  assign rd_data = empty ? '0 : mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_fire) wr_ptr <= wr_ptr + 1'b1;
      if (rd_fire) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_fire) mem[wr_ptr[AW-1:0]] <= wr_data;
  end
endmodule

// File: rtl/axis_period_packer.sv
// Buffers an LFSR AXI-Stream through a FIFO, re-emits it with tlast every
// PKT_LEN beats, and measures the input sequence period.
//   aclk, areset          : clock, synchronous active-high reset
//   s_axis (slave)        : input stream (tlast ignored)
//   m_axis (master)       : framed output stream
//   clear                 : restart period measurement
//   period, period_valid  : last completed period in accepted input beats
//   fifo_level            : FIFO occupancy
module axis_period_packer
  import axis_pkg::*;
#(
  parameter int C_AXIS_DATA_WIDTH = C_AXIS_DATA_WIDTH_DEF,
  parameter int FIFO_DEPTH        = 16,
  parameter int PKT_LEN           = 16
) (
  input  logic                          aclk,
  input  logic                          areset,
  axis_period_packer_if.slave           s_axis,
  axis_period_packer_if.master          m_axis,
  input  logic                          clear,
  output logic [PERIOD_W-1:0]           period,
  output logic                          period_valid,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);
  localparam int BW = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1;

  logic full, empty, in_acc, out_done;
  logic unused_s_tlast;

  assign unused_s_tlast = s_axis.tlast;

  // Ready is held low during reset so nothing is accepted in that cycle.
  assign s_axis.tready = !full && !areset;
  assign in_acc        = s_axis.tvalid && s_axis.tready;
  assign m_axis.tvalid = !empty;
  assign out_done      = m_axis.tvalid && m_axis.tready;

  axis_sync_fifo #(
    .W     (C_AXIS_DATA_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (aclk),
    .rst     (areset),
    .wr_en   (in_acc),
    .wr_data (s_axis.tdata),
    .full    (full),
    .rd_en   (m_axis.tready),
    .rd_data (m_axis.tdata),
    .empty   (empty),
    .level   (fifo_level)
  );

  // Packet framing: counts completed output beats.
  logic [BW-1:0] beat_cnt;
  logic          beat_last;

  assign beat_last   = (beat_cnt == BW'(PKT_LEN-1));
  assign m_axis.tlast = !empty && beat_last;

  always_ff @(posedge aclk) begin
    if (areset)        beat_cnt <= '0;
    else if (out_done) beat_cnt <= beat_last ? '0 : beat_cnt + 1'b1;
  end

  // Period measurement FSM, driven by input handshakes only.
  meas_state_e                  state, state_nx;
  logic [C_AXIS_DATA_WIDTH-1:0] ref_word, ref_word_nx;
  logic [PERIOD_W-1:0]          pcnt, pcnt_nx, pcnt_inc;
  logic [PERIOD_W-1:0]          period_nx;
  logic                         period_valid_nx;

  assign pcnt_inc = sat_inc(pcnt);

  always_ff @(posedge aclk) begin
    if (areset) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    if (clear) begin
      state_nx = IDLE;
    end else begin
      case (state)
        IDLE:    if (in_acc) state_nx = MEASURE;
        MEASURE: state_nx = MEASURE;
        default: state_nx = IDLE;
      endcase
    end
  end

  // clear wins over a coincident beat: that beat is not taken as reference.
  always_comb begin
    ref_word_nx     = ref_word;
    pcnt_nx         = pcnt;
    period_nx       = period;
    period_valid_nx = period_valid;
    if (clear) begin
      period_nx       = '0;
      period_valid_nx = 1'b0;
    end else if (in_acc) begin
      if (state == IDLE) begin
        ref_word_nx = s_axis.tdata;
        pcnt_nx     = '0;
      end else if (s_axis.tdata == ref_word) begin
        period_nx       = pcnt_inc;
        period_valid_nx = 1'b1;
        pcnt_nx         = '0;
      end else begin
        pcnt_nx = pcnt_inc;
      end
    end
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      ref_word     <= '0;
      pcnt         <= '0;
      period       <= '0;
      period_valid <= 1'b0;
    end else begin
      ref_word     <= ref_word_nx;
      pcnt         <= pcnt_nx;
      period       <= period_nx;
      period_valid <= period_valid_nx;
    end
  end
endmodule

// File: tb/tb_axis_period_packer.sv
// Randomized scoreboard bench for axis_period_packer.
module tb_axis_period_packer;
  localparam int W     = 32;
  localparam int DEPTH = 16;
  localparam int PKT   = 16;

  logic        aclk = 1'b0;
  logic        areset;
  logic        clear;
  logic [15:0] period;
  logic        period_valid;
  logic [4:0]  fifo_level;

  axis_period_packer_if #(.W(W)) s_if ();
  axis_period_packer_if #(.W(W)) m_if ();

  axis_period_packer #(
    .C_AXIS_DATA_WIDTH (W),
    .FIFO_DEPTH        (DEPTH),
    .PKT_LEN           (PKT)
  ) dut (
    .aclk         (aclk),
    .areset       (areset),
    .s_axis       (s_if),
    .m_axis       (m_if),
    .clear        (clear),
    .period       (period),
    .period_valid (period_valid),
    .fifo_level   (fifo_level)
  );

  always #5 aclk = ~aclk;

  typedef struct {
    logic [W-1:0] d;
    logic         l;
  } exp_t;

  int          total = 0;
  int          bad   = 0;
  exp_t        exp_q[$];
  int          m_level;
  int          n_in;
  bit          m_idle;
  logic [W-1:0] m_ref;
  int          ref_idx;
  logic [15:0] m_per;
  bit          m_pv;
  bit          acc_flag;
  bit          rst_seen;
  bit          chk_en = 0;
  int          rdy_mode = 1;

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: FIFO as occupancy count, output order = input order,
  // tlast from the input beat index, period as distance between recurrences.
  always @(posedge aclk) begin
    bit acc, done;
    if (areset) begin
      exp_q.delete();
      m_level  = 0;
      n_in     = 0;
      m_idle   = 1;
      m_per    = 0;
      m_pv     = 0;
      acc_flag = 0;
      rst_seen = 1;
    end else begin
      rst_seen = 0;
      acc  = s_if.tvalid && (m_level < DEPTH);
      done = m_if.tready && (m_level > 0);
      acc_flag = acc;
      if (clear) begin
        m_idle = 1;
        m_per  = 0;
        m_pv   = 0;
      end else if (acc) begin
        if (m_idle) begin
          m_ref   = s_if.tdata;
          ref_idx = n_in;
          m_idle  = 0;
        end else if (s_if.tdata == m_ref) begin
          m_per   = ((n_in - ref_idx) > 65535) ? 16'hFFFF : 16'(n_in - ref_idx);
          m_pv    = 1;
          ref_idx = n_in;
        end
      end
      if (acc) begin
        exp_q.push_back('{d: s_if.tdata, l: ((n_in % PKT) == PKT-1)});
        n_in++;
      end
      m_level = m_level + int'(acc) - int'(done);
    end
  end

  // Monitor: sampled on the falling edge.
  always @(negedge aclk) begin
    if (chk_en) begin
      chk("s_tready", {31'b0, s_if.tready}, {31'b0, !areset && (m_level < DEPTH)});
      chk("m_tvalid", {31'b0, m_if.tvalid}, {31'b0, m_level > 0});
      chk("fifo_level", {27'b0, fifo_level}, W'(m_level));
      chk("period", {16'b0, period}, {16'b0, m_per});
      chk("period_valid", {31'b0, period_valid}, {31'b0, m_pv});
      if (rst_seen && areset) begin
        chk("rst_tdata", m_if.tdata, '0);
        chk("rst_tlast", {31'b0, m_if.tlast}, '0);
      end
      if (m_if.tvalid) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_out", 32'd1, 32'd0);
        end else begin
          chk("m_tdata", m_if.tdata, exp_q[0].d);
          chk("m_tlast", {31'b0, m_if.tlast}, {31'b0, exp_q[0].l});
          if (m_if.tready) void'(exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    m_if.tready = 1'b1;
    forever begin
      @(posedge aclk);
      #1;
      case (rdy_mode)
        0:       m_if.tready = 1'b0;
        1:       m_if.tready = 1'b1;
        default: m_if.tready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic cyc();
    @(posedge aclk);
    #1;
  endtask

  task automatic do_reset(input int n);
    areset = 1'b1;
    s_if.tvalid = 1'b0;
    clear = 1'b0;
    repeat (n) cyc();
    areset = 1'b0;
  endtask

  task automatic send(input logic [W-1:0] d, input bit clr);
    bit ok;
    ok = 0;
    s_if.tvalid = 1'b1;
    s_if.tdata  = d;
    clear       = clr;
    for (int k = 0; k < 200; k++) begin
      cyc();
      clear = 1'b0;
      if (acc_flag) begin
        ok = 1;
        break;
      end
    end
    if (!ok) chk("send_timeout", 32'd1, 32'd0);
    s_if.tvalid = 1'b0;
  endtask

  initial begin
    logic [W-1:0] seq [5];
    seq[0] = 3; seq[1] = 7; seq[2] = 1; seq[3] = 9; seq[4] = 4;
    areset = 1'b1;
    clear  = 1'b0;
    s_if.tvalid = 1'b0;
    s_if.tdata  = '0;
    s_if.tlast  = 1'b0;
    repeat (2) cyc();
    chk_en = 1;
    do_reset(2);

    // single word
    send(32'h5A, 0);
    repeat (3) cyc();

    // backpressure to full, then drain
    do_reset(2);
    rdy_mode = 0;
    for (int i = 0; i < 20; i++) begin
      s_if.tvalid = 1'b1;
      s_if.tdata  = $urandom;
      cyc();
    end
    s_if.tvalid = 1'b0;
    rdy_mode = 1;
    repeat (20) cyc();

    // framing with random downstream stalls
    do_reset(2);
    rdy_mode = 2;
    for (int i = 0; i < 40; i++) send($urandom, 0);
    rdy_mode = 1;
    repeat (20) cyc();

    // period measurement, then clear coinciding with a beat
    do_reset(2);
    for (int i = 0; i < 22; i++) send(seq[i % 5], 0);
    send(seq[22 % 5], 1);
    for (int i = 23; i < 40; i++) send(seq[i % 5], 0);
    repeat (3) cyc();

    // reset mid-packet
    do_reset(2);
    for (int i = 0; i < 3; i++) send($urandom, 0);
    repeat (2) cyc();
    rdy_mode = 0;
    for (int i = 0; i < 5; i++) send($urandom, 0);
    cyc();
    do_reset(1);
    rdy_mode = 1;
    for (int i = 0; i < 20; i++) send($urandom, 0);
    repeat (5) cyc();

    // random traffic with small alphabet and random clears
    do_reset(2);
    rdy_mode = 2;
    for (int i = 0; i < 400; i++) begin
      s_if.tvalid = 1'($urandom_range(0, 1));
      s_if.tdata  = W'($urandom_range(0, 3));
      clear       = ($urandom_range(0, 15) == 0);
      cyc();
    end
    s_if.tvalid = 1'b0;
    clear = 1'b0;
    rdy_mode = 1;
    repeat (40) cyc();
    chk("drain_empty", W'(exp_q.size()), '0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
